// File: rtl/bias_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bias_seq_ctrl_pkg
// Description : Shared definitions for the bias sequencer. Holds the default
//               channel count, accumulator width, bias ROM geometry and init
//               file name, the accumulator vector type and the sequencer
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bias_seq_ctrl_pkg;

  // Output channels per accumulator vector (and bias bank entries).
  localparam int K_CHANNELS         = 4;
  // Signed accumulator / bias word width.
  localparam int ACC_WIDTH          = 16;
  // Total bias words stored in the shared ROM, all layers together.
  localparam int ROM_BIAS_DEPTH     = 10;
  // Image used by whoever instantiates the shared bias ROM.
  localparam string ROM_BIAS_INIT_FILE = "bias_rom.mem";

  // One signed lane and one full vector of K_CHANNELS lanes.
  typedef logic signed [ACC_WIDTH-1:0] acc_lane_t;
  typedef acc_lane_t [K_CHANNELS-1:0]  acc_vec_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } bias_state_e;

endpackage : bias_seq_ctrl_pkg
`default_nettype wire

// File: rtl/bias_seq_ctrl_sat_add_lane.sv
`default_nettype none
// ============================================================================
// Module      : bias_seq_ctrl_sat_add_lane
// Description : Combinational signed saturating adder for one lane.
//               The sum is formed one bit wider than the operands; when the
//               two top bits disagree the result is clamped to the most
//               positive or most negative ACC_W-bit value.
// Ports       : a_i   - signed accumulator lane
//               b_i   - signed bias
//               sum_o - saturated a_i + b_i
// Revision    : 1.0 - initial release
// ============================================================================
module bias_seq_ctrl_sat_add_lane #(
  parameter int ACC_W = 16
) (
  input  logic signed [ACC_W-1:0] a_i,
  input  logic signed [ACC_W-1:0] b_i,
  output logic signed [ACC_W-1:0] sum_o
);

  localparam logic signed [ACC_W-1:0] C_SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] C_SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] w_ext_sum;

  always_comb begin
    w_ext_sum = {a_i[ACC_W-1], a_i} + {b_i[ACC_W-1], b_i};
    // Top two bits differ only when the true sum left the ACC_W range;
    // the extra sign bit tells which way it went.
    if (w_ext_sum[ACC_W] != w_ext_sum[ACC_W-1]) begin
      sum_o = w_ext_sum[ACC_W] ? C_SAT_MIN : C_SAT_MAX;
    end else begin
      sum_o = w_ext_sum[ACC_W-1:0];
    end
  end

endmodule : bias_seq_ctrl_sat_add_lane
`default_nettype wire

// File: rtl/bias_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bias_seq_ctrl
// Description : Per-layer bias sequencer and bias-add stage.
//               On start_i the block reads K_CH consecutive words (modulo
//               DEPTH) from the shared synchronous bias ROM into a local bias
//               bank, then streams accumulator vectors through a saturating
//               lane-wise bias add into a single-stage output register.
// Ports       : clk_i, rst_n_i       - clock, asynchronous active-low reset
//               start_i, base_addr_i - load request and first ROM word
//               rom_en_o, rom_addr_o - bias ROM read port
//               rom_data_i           - ROM data, one cycle after rom_en_o
//               acc_valid_i/_ready_o - accumulator vector handshake
//               acc_data_i           - K_CH signed accumulator lanes
//               out_valid_o/ready_i  - biased vector handshake
//               out_data_o           - K_CH signed saturated sums
//               busy_o               - bank load in progress
//               done_o               - one-cycle pulse, bank fully loaded
// Revision    : 1.0 - initial release
// ============================================================================
module bias_seq_ctrl
  import bias_seq_ctrl_pkg::*;
#(
  parameter int K_CH   = K_CHANNELS,
  parameter int ACC_W  = ACC_WIDTH,
  parameter int DEPTH  = ROM_BIAS_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  output logic                  rom_en_o,
  output logic [ADDR_W-1:0]     rom_addr_o,
  input  logic [ACC_W-1:0]      rom_data_i,
  input  logic                  acc_valid_i,
  output logic                  acc_ready_o,
  input  logic [K_CH*ACC_W-1:0] acc_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [K_CH*ACC_W-1:0] out_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int                CNT_W      = (K_CH > 1) ? $clog2(K_CH) : 1;
  localparam logic [CNT_W-1:0]  C_LAST_RD  = CNT_W'(K_CH - 1);
  localparam logic [ADDR_W-1:0] C_ADDR_MAX = ADDR_W'(DEPTH - 1);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  bias_state_e             r_state;
  bias_state_e             w_state_nxt;

  logic [ADDR_W-1:0]       r_addr;       // next ROM address to read
  logic [CNT_W-1:0]        r_cnt;        // index of the read being issued
  logic                    r_cap_vld;    // ROM data for bank[r_cap_idx] is on rom_data_i
  logic [CNT_W-1:0]        r_cap_idx;
  logic                    r_done;
  logic signed [ACC_W-1:0] r_bank [K_CH];

  logic                    r_out_valid;
  logic [K_CH*ACC_W-1:0]   r_out_data;

  logic                    w_load_go;
  logic                    w_rom_en;
  logic                    w_busy;
  logic                    w_acc_ready;
  logic                    w_accept;
  logic signed [ACC_W-1:0] w_bias [K_CH];
  logic [K_CH*ACC_W-1:0]   w_sum;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load_go   = 1'b0;
    w_rom_en    = 1'b0;
    w_busy      = 1'b0;
    w_acc_ready = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = ST_LOAD;
          w_load_go   = 1'b1;
        end
      end

      ST_LOAD: begin
        // start_i is ignored here; the load always runs to completion.
        w_rom_en = 1'b1;
        w_busy   = 1'b1;
        if (r_cnt == C_LAST_RD) begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (start_i) begin
          // A reload may only start once nothing is left in the output
          // register after this edge; no vector is accepted in that cycle.
          if (!r_out_valid || out_ready_i) begin
            w_state_nxt = ST_LOAD;
            w_load_go   = 1'b1;
          end
        end else begin
          w_acc_ready = !r_out_valid || out_ready_i;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_accept = w_acc_ready & acc_valid_i;

  // --------------------------------------------------------------------------
  // ROM read sequencing and bias bank capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_addr    <= '0;
      r_cnt     <= '0;
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
      r_done    <= 1'b0;
      for (int k = 0; k < K_CH; k++) begin
        r_bank[k] <= '0;
      end
    end else begin
      // Data for a read appears one cycle later; remember where it goes.
      r_cap_vld <= w_rom_en;
      r_cap_idx <= r_cnt;
      r_done    <= w_rom_en && (r_cnt == C_LAST_RD);

      if (r_cap_vld) begin
        r_bank[r_cap_idx] <= rom_data_i;
      end

      if (w_load_go) begin
        r_addr <= base_addr_i;
        r_cnt  <= '0;
      end else if (w_rom_en) begin
        // The layer may straddle the end of the ROM; wrap at DEPTH, which
        // need not be a power of two.
        r_addr <= (r_addr == C_ADDR_MAX) ? '0 : r_addr + 1'b1;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bias add lanes
  // --------------------------------------------------------------------------
  // RUN is entered in the same cycle the last bias word is still on
  // rom_data_i, so a vector accepted then takes that lane's bias straight
  // from the ROM rather than from the not-yet-written bank entry.
  generate
    for (genvar k = 0; k < K_CH; k++) begin : g_lane
      assign w_bias[k] = (r_cap_vld && (r_cap_idx == CNT_W'(k))) ? rom_data_i
                                                                 : r_bank[k];

      bias_seq_ctrl_sat_add_lane #(
        .ACC_W (ACC_W)
      ) u_sat_add_lane (
        .a_i   (acc_data_i[k*ACC_W +: ACC_W]),
        .b_i   (w_bias[k]),
        .sum_o (w_sum[k*ACC_W +: ACC_W])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output register: holds while stalled, reloads on accept, empties on drain
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sum;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rom_en_o    = w_rom_en;
  assign rom_addr_o  = w_rom_en ? r_addr : '0;
  assign acc_ready_o = w_acc_ready;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign busy_o      = w_busy;
  assign done_o      = r_done;

endmodule : bias_seq_ctrl
`default_nettype wire

// File: tb/tb_bias_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bias_seq_ctrl
// Description : Self-checking bench for bias_seq_ctrl (K_CH=4, ACC_W=16,
//               DEPTH=10) with a behavioural ROM and reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bias_seq_ctrl;

  localparam int K  = 4;
  localparam int W  = 16;
  localparam int D  = 10;
  localparam int AW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic           rom_en;
  logic [AW-1:0]  rom_addr;
  logic [W-1:0]   rom_data;
  logic           acc_valid;
  logic           acc_ready;
  logic [K*W-1:0] acc_data;
  logic           out_valid;
  logic           out_ready;
  logic [K*W-1:0] out_data;
  logic           busy;
  logic           done;

  bias_seq_ctrl #(
    .K_CH   (K),
    .ACC_W  (W),
    .DEPTH  (D),
    .ADDR_W (AW)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .rom_en_o    (rom_en),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .acc_valid_i (acc_valid),
    .acc_ready_o (acc_ready),
    .acc_data_i  (acc_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  // Synchronous bias ROM.
  logic signed [W-1:0] rom [D];
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom[int'(rom_addr)];
  end

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int           m_bank [K];
  bit           m_run;
  bit           m_ov;
  logic [K*W-1:0] m_od;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lane k: clamp(acc[k] + bias[k]) to the signed 16-bit range.
  function automatic logic [K*W-1:0] ref_sum(input logic [K*W-1:0] d);
    logic [K*W-1:0] r;
    int s;
    r = '0;
    for (int k = 0; k < K; k++) begin
      s = int'($signed(d[k*W +: W])) + m_bank[k];
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      r[k*W +: W] = s[15:0];
    end
    return r;
  endfunction

  // One RUN-mode cycle: drive, check at negedge, advance the model.
  task automatic step(input bit v, input logic [K*W-1:0] d, input bit rdy,
                      input bit st, input string tag);
    bit exp_rdy;
    @(posedge clk); #1;
    acc_valid = v; acc_data = d; out_ready = rdy; start = st;
    @(negedge clk);
    exp_rdy = m_run && !st && (!m_ov || rdy);
    chk({tag, "/acc_ready"}, 64'(acc_ready), 64'(exp_rdy));
    chk({tag, "/out_valid"}, 64'(out_valid), 64'(m_ov));
    if (m_ov) chk({tag, "/out_data"}, out_data, m_od);
    chk({tag, "/busy"}, 64'(busy), 64'(0));
    chk({tag, "/done"}, 64'(done), 64'(0));
    chk({tag, "/rom_en"}, 64'(rom_en), 64'(0));
    if (exp_rdy && v) begin
      m_ov = 1'b1;
      m_od = ref_sum(d);
    end else if (rdy) begin
      m_ov = 1'b0;
    end
  endtask

  // Start a load (draining any pending output), check the read sequence and
  // the done cycle, and send vector fwd in the done cycle.
  task automatic do_load(input int base, input logic [K*W-1:0] fwd);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(base); acc_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("load/start_acc_ready", 64'(acc_ready), 64'(0));
    chk("load/start_out_valid", 64'(out_valid), 64'(m_ov));
    chk("load/start_busy", 64'(busy), 64'(0));
    m_ov = 1'b0;
    for (int j = 0; j < K; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("load/rom_en", 64'(rom_en), 64'(1));
      chk("load/rom_addr", 64'(rom_addr), 64'((base + j) % D));
      chk("load/busy", 64'(busy), 64'(1));
      chk("load/done_early", 64'(done), 64'(0));
      chk("load/acc_ready", 64'(acc_ready), 64'(0));
      chk("load/out_valid", 64'(out_valid), 64'(0));
    end
    for (int j = 0; j < K; j++) m_bank[j] = int'(rom[(base + j) % D]);
    @(posedge clk); #1;
    acc_valid = 1'b1; acc_data = fwd; out_ready = 1'b1;
    @(negedge clk);
    chk("load/done", 64'(done), 64'(1));
    chk("load/done_busy", 64'(busy), 64'(0));
    chk("load/done_rom_en", 64'(rom_en), 64'(0));
    chk("load/done_acc_ready", 64'(acc_ready), 64'(1));
    m_run = 1'b1;
    m_ov  = 1'b1;
    m_od  = ref_sum(fwd);
  endtask

  logic [K*W-1:0] v100;
  logic [K*W-1:0] vsat;
  logic [K*W-1:0] c_exp100;

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; acc_valid = 1'b0;
    acc_data = '0; out_ready = 1'b0; rom_data = '0;
    for (int i = 0; i < D; i++) rom[i] = W'($urandom);
    rom[8] = 16'sd1; rom[9] = -16'sd2; rom[0] = 16'sd3; rom[1] = -16'sd4;
    for (int k = 0; k < K; k++) m_bank[k] = 0;
    m_run = 1'b0; m_ov = 1'b0; m_od = '0;
    v100     = {4{16'd100}};
    c_exp100 = {16'd96, 16'd103, 16'd98, 16'd101};

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst/rom_en", 64'(rom_en), 64'(0));
    chk("rst/rom_addr", 64'(rom_addr), 64'(0));
    chk("rst/acc_ready", 64'(acc_ready), 64'(0));
    chk("rst/out_valid", 64'(out_valid), 64'(0));
    chk("rst/out_data", out_data, 64'(0));
    chk("rst/busy", 64'(busy), 64'(0));
    chk("rst/done", 64'(done), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; acc_valid = 1'b1;
    @(negedge clk);
    chk("idle/acc_ready", 64'(acc_ready), 64'(0));

    // Wrapping load at base 8: addresses 8,9,0,1 -> bank {1,-2,3,-4}.
    do_load(8, v100);

    // Back-to-back vectors, output ready held.
    repeat (6) begin
      step(1'b1, v100, 1'b1, 1'b0, "b2b");
      chk("b2b/plan_value", out_data, c_exp100);
    end

    // Saturation at both ends, then a 3-cycle stall with a start pulse.
    vsat = {16'h8000, 16'($urandom), 16'($urandom), 16'h7FFF};
    step(1'b1, vsat, 1'b1, 1'b0, "sat");
    repeat (3) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, "stall");
    chk("sat/lane0", 64'(out_data[15:0]), 64'h7FFF);
    chk("sat/lane3", 64'(out_data[63:48]), 64'h8000);
    step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, "stall_start");
    step(1'b0, '0, 1'b1, 1'b0, "after_stall");
    step(1'b0, '0, 1'b1, 1'b0, "idle_run");

    // Random traffic, reload from a random base, more random traffic.
    repeat (40) step(1'($urandom_range(0, 1)), {$urandom, $urandom},
                     ($urandom_range(0, 3) != 0), 1'b0, "rand1");
    do_load($urandom_range(0, D - 1), {$urandom, $urandom});
    repeat (30) step(1'($urandom_range(0, 1)), {$urandom, $urandom},
                     ($urandom_range(0, 3) != 0), 1'b0, "rand2");

    // Reset on the 2nd LOAD cycle.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 4'd2; acc_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstload/rom_en", 64'(rom_en), 64'(0));
    chk("rstload/rom_addr", 64'(rom_addr), 64'(0));
    chk("rstload/busy", 64'(busy), 64'(0));
    chk("rstload/out_valid", 64'(out_valid), 64'(0));
    chk("rstload/out_data", out_data, 64'(0));
    repeat (3) begin
      @(negedge clk);
      chk("rstload/done", 64'(done), 64'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1; acc_valid = 1'b1;
    m_run = 1'b0; m_ov = 1'b0;
    for (int k = 0; k < K; k++) m_bank[k] = 0;
    repeat (2) begin
      @(negedge clk);
      chk("rstload/idle_busy", 64'(busy), 64'(0));
      chk("rstload/idle_rom_en", 64'(rom_en), 64'(0));
      chk("rstload/idle_acc_ready", 64'(acc_ready), 64'(0));
      chk("rstload/idle_done", 64'(done), 64'(0));
    end

    do_load(5, {$urandom, $urandom});
    repeat (20) step(1'($urandom_range(0, 1)), {$urandom, $urandom},
                     ($urandom_range(0, 3) != 0), 1'b0, "rand3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bias_seq_ctrl
`default_nettype wire

// File: doc/bias_seq_ctrl.md
Name: bias_seq_ctrl

Overview:
- Sequences per-layer bias loading from the shared multi-layer bias ROM (synchronous read, one word/cycle) into a local K_CH-entry bias bank.
- Then streams accumulator vectors from the PE array through a saturating bias-add stage to the requant/activation stage.
- Sits between the PE accumulator output and the post-processing pipeline; owns the bias ROM read port.

Parameters:
- K_CH, K_CHANNELS, output channels per vector / bias bank entries
- ACC_W, ACC_WIDTH, signed accumulator and bias width
- DEPTH, ROM_BIAS_DEPTH, total bias ROM words across all layers
- ADDR_W, $clog2(DEPTH), ROM address width

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  pulse: load biases for a new layer
- base_addr_i  in  ADDR_W  first ROM word of the layer, sampled with start_i
- rom_en_o  out  1  ROM read enable
- rom_addr_o  out  ADDR_W  ROM read address
- rom_data_i  in  ACC_W  ROM read data, valid 1 cycle after rom_en_o
- acc_valid_i  in  1  accumulator vector valid
- acc_ready_o  out  1  accumulator vector accepted
- acc_data_i  in  K_CH*ACC_W  signed accumulator lanes
- out_valid_o  out  1  biased vector valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  K_CH*ACC_W  signed saturated sums, lane k = acc[k] + bias[k]
- busy_o  out  1  high in LOAD
- done_o  out  1  one-cycle pulse when the bias bank is fully loaded

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE, bank cleared to 0, rom_en_o=0, rom_addr_o=0, acc_ready_o=0, out_valid_o=0, out_data_o=0, busy_o=0, done_o=0.
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - start_i=1 -> LOAD; latch base_addr_i; read counter=0.
  - acc_ready_o=0.
- LOAD:
  - Issue K_CH consecutive reads, one per cycle, rom_en_o=1, addresses base..base+K_CH-1 modulo DEPTH. Wrap from DEPTH-1 to 0, not to 2^ADDR_W.
  - Capture rom_data_i into bank[j] one cycle after read j.
  - Load latency is exactly K_CH+1 cycles from the start_i cycle to the done_o cycle.
  - done_o pulses in the cycle after the last capture, and the FSM enters RUN in that same cycle.
  - busy_o=1, acc_ready_o=0, start_i ignored.
- RUN:
  - Single-stage output register. acc_ready_o = !out_valid_o | out_ready_i.
  - On acc_valid_i & acc_ready_o: register saturated sums and set out_valid_o=1.
  - On out_ready_i with no new accept: clear out_valid_o.
  - Simultaneous accept and drain gives back-to-back throughput of 1 vector/cycle with no bubble.
  - out_data_o holds stable while out_valid_o & !out_ready_i.
- Arithmetic:
  - Each lane adds in ACC_W+1 bits.
  - Overflow saturates to 2^(ACC_W-1)-1; underflow saturates to -2^(ACC_W-1).
- start_i in RUN:
  - Accepted only when out_valid_o=0, or when out_valid_o & out_ready_i in the same cycle. The accumulator must not be accepted in that cycle: acc_ready_o is forced 0 when start_i=1. Go to LOAD.
  - Otherwise ignored; the issuer must re-pulse.
- The bias bank is overwritten only during LOAD. Old values remain until each entry is overwritten.
- Reset mid-LOAD or mid-RUN returns to the reset values immediately. Any pending output is discarded.

Decomposition:
- Shared definitions package holds: K_CHANNELS, ACC_WIDTH, ROM_BIAS_DEPTH, ROM_BIAS_INIT_FILE, and a typedef for an acc vector (K_CHANNELS x ACC_WIDTH signed) and its state enum.
- One natural sub-module: sat_add_lane (combinational, ACC_W signed saturating add), instantiated K_CH times.
- The bias ROM itself stays external and is driven via rom_en_o/rom_addr_o.

Test Plan:
- K_CH=4, ACC_W=16, ROM[8..11]={1,-2,3,-4}, start_i with base=8 -> rom_addr_o 8,9,10,11 on consecutive cycles; done_o exactly 5 cycles after start; bank={1,-2,3,-4}.
- DEPTH=10, base=8 -> addresses 8,9,0,1; bank loads ROM[8],ROM[9],ROM[0],ROM[1].
- RUN, acc={100,100,100,100}, out_ready_i=1 held, 6 vectors back-to-back -> out {101,98,103,96} each cycle, 1-cycle latency, no bubbles.
- acc lane0=32767 with bias 1, and lane3=-32768 with bias -4 -> out lane0=32767, lane3=-32768.
- out_ready_i=0 for 3 cycles with out_valid_o=1 -> acc_ready_o=0 and out_data_o stable; start_i pulsed during the stall is ignored and the state stays RUN.
- rst_n_i asserted on the 2nd LOAD cycle -> all outputs 0 immediately; no done_o pulse; state IDLE after release.
